// File: rtl/ysyx_22040365_wbu.sv
// ysyx_22040365_wbu: write-back unit with 2-entry skid FIFO, 32x64 regfile, bypassed read ports, retire trace
//   in : clk, rst (sync, active-high), ex_valid/ex_rd/ex_wen_rd/ex_result/ex_pc (EX result),
//        wb_stall (freeze retirement), rs1_addr/rs2_addr (read indices)
//   out: ex_ready (FIFO not full), rs1_data/rs2_data (combinational, bypassed),
//        commit_valid/commit_pc (retire pulse), retire_cnt (retired entry count)
module ysyx_22040365_wbu #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_wen_rd,
  input  logic [XLEN-1:0]    ex_result,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic               wb_stall,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data,
  output logic               commit_valid,
  output logic [XLEN-1:0]    commit_pc,
  output logic [XLEN-1:0]    retire_cnt
);
  logic [XLEN-1:0]    rf [2**RADDR_W];
  logic [RADDR_W-1:0] e_rd [2];
  logic               e_wen [2];
  logic [XLEN-1:0]    e_res [2];
  logic [XLEN-1:0]    e_pc [2];
  logic [1:0]         count;
  logic               rd_ptr, wr_ptr, push, pop, ov, yv;
  logic [RADDR_W-1:0] ra [2];
  logic [XLEN-1:0]    rdat [2];
  assign ex_ready = count < 2'd2;
  assign push = ex_valid & ex_ready;
  assign pop = (count != 2'd0) & ~wb_stall;
  // head entry (rd_ptr) is the older one; the other slot is pending only when full
  assign ov = count != 2'd0;
  assign yv = count == 2'd2;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      commit_valid <= 1'b0;
      commit_pc <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < 2**RADDR_W; i++) rf[i] <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      commit_valid <= pop;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        retire_cnt <= retire_cnt + 1'b1;
        commit_pc <= e_pc[rd_ptr];
        if (e_wen[rd_ptr] && e_rd[rd_ptr] != '0) rf[e_rd[rd_ptr]] <= e_res[rd_ptr];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      e_rd[wr_ptr] <= ex_rd;
      e_wen[wr_ptr] <= ex_wen_rd;
      e_res[wr_ptr] <= ex_result;
      e_pc[wr_ptr] <= ex_pc;
    end
  end
  assign ra[0] = rs1_addr;
  assign ra[1] = rs2_addr;
  for (genvar g = 0; g < 2; g++) begin : g_rd
    assign rdat[g] = (ra[g] == '0) ? '0 :
                     (yv && e_wen[~rd_ptr] && e_rd[~rd_ptr] == ra[g]) ? e_res[~rd_ptr] :
                     (ov && e_wen[rd_ptr] && e_rd[rd_ptr] == ra[g]) ? e_res[rd_ptr] :
                     rf[ra[g]];
  end
  assign rs1_data = rdat[0];
  assign rs2_data = rdat[1];
endmodule

// File: tb/tb_ysyx_22040365_wbu.sv
// tb_ysyx_22040365_wbu: directed table-driven bench for the write-back unit
module tb_ysyx_22040365_wbu;
  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_ready, ex_wen_rd, wb_stall, commit_valid;
  logic [4:0]  ex_rd, rs1_addr, rs2_addr;
  logic [63:0] ex_result, ex_pc, rs1_data, rs2_data, commit_pc, retire_cnt;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ysyx_22040365_wbu dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_wen_rd(ex_wen_rd), .ex_result(ex_result), .ex_pc(ex_pc), .wb_stall(wb_stall),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .retire_cnt(retire_cnt)
  );
  typedef struct {
    logic r, v; logic [4:0] rd; logic w; logic [63:0] res, pc; logic st; logic [4:0] a1, a2;
    logic chk, rdy; logic [63:0] d1, d2; logic cv; logic [63:0] cpc, cnt;
  } vec_t;
  vec_t tv [$];
  function automatic vec_t mk(logic r, logic v, logic [4:0] rd, logic w, logic [63:0] res, logic [63:0] pc,
                              logic st, logic [4:0] a1, logic [4:0] a2, logic chk, logic rdy,
                              logic [63:0] d1, logic [63:0] d2, logic cv, logic [63:0] cpc, logic [63:0] cnt);
    vec_t t;
    t.r = r; t.v = v; t.rd = rd; t.w = w; t.res = res; t.pc = pc; t.st = st; t.a1 = a1; t.a2 = a2;
    t.chk = chk; t.rdy = rdy; t.d1 = d1; t.d2 = d2; t.cv = cv; t.cpc = cpc; t.cnt = cnt;
    return t;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // inputs change after the falling edge and outputs are sampled 1ns later;
  // the next rising edge then consumes the driven inputs
  task automatic drive(input logic r, input logic v, input logic [4:0] rd, input logic w,
                       input logic [63:0] res, input logic [63:0] pc, input logic st,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rst = r; ex_valid = v; ex_rd = rd; ex_wen_rd = w; ex_result = res; ex_pc = pc;
    wb_stall = st; rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask
  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_wen_rd = 1'b0; ex_result = '0; ex_pc = '0;
    wb_stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
    tv.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,5,1,64'h10,64'h8000_0000,0,5,0, 1,1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,5,0, 1,1,64'h10,0,0,0,0));
    tv.push_back(mk(0,1,0,1,64'hDEAD,64'h8000_0004,0,0,5, 1,1,0,64'h10,1,64'h8000_0000,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,5, 1,1,0,64'h10,0,64'h8000_0000,1));
    tv.push_back(mk(0,1,3,1,64'hA,64'h8000_0008,1,0,3, 1,1,0,0,1,64'h8000_0004,2));
    tv.push_back(mk(0,1,3,1,64'hB,64'h8000_000C,1,0,3, 1,1,0,64'hA,0,64'h8000_0004,2));
    tv.push_back(mk(0,1,9,1,64'h77,64'h8000_0010,1,9,3, 1,0,0,64'hB,0,64'h8000_0004,2));
    tv.push_back(mk(0,1,9,1,64'h77,64'h8000_0010,0,9,3, 1,0,0,64'hB,0,64'h8000_0004,2));
    tv.push_back(mk(0,1,9,1,64'h77,64'h8000_0010,0,9,3, 1,1,0,64'hB,1,64'h8000_0008,3));
    tv.push_back(mk(0,0,0,0,0,0,0,9,3, 1,1,64'h77,64'hB,1,64'h8000_000C,4));
    tv.push_back(mk(0,1,7,0,64'h55,64'h8000_0014,0,7,9, 1,1,0,64'h77,1,64'h8000_0010,5));
    tv.push_back(mk(0,0,0,0,0,0,0,7,9, 1,1,0,64'h77,0,64'h8000_0010,5));
    tv.push_back(mk(0,0,0,0,0,0,0,7,3, 1,1,0,64'hB,1,64'h8000_0014,6));
    tv.push_back(mk(0,0,0,0,0,0,0,7,3, 1,1,0,64'hB,0,64'h8000_0014,6));
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].v, tv[i].rd, tv[i].w, tv[i].res, tv[i].pc, tv[i].st, tv[i].a1, tv[i].a2);
      if (tv[i].chk) begin
        chk($sformatf("v%0d ex_ready", i), 64'(ex_ready), 64'(tv[i].rdy));
        chk($sformatf("v%0d rs1_data", i), rs1_data, tv[i].d1);
        chk($sformatf("v%0d rs2_data", i), rs2_data, tv[i].d2);
        chk($sformatf("v%0d commit_valid", i), 64'(commit_valid), 64'(tv[i].cv));
        chk($sformatf("v%0d commit_pc", i), commit_pc, tv[i].cpc);
        chk($sformatf("v%0d retire_cnt", i), retire_cnt, tv[i].cnt);
      end
    end
    // streaming: after the first push the FIFO holds one entry while pushing and popping every cycle
    for (int k = 0; k < 11; k++) begin
      if (k < 9) drive(0, 1, 10, 1, 64'(k + 100), 64'h9000_0000 + 64'(4 * k), 0, 10, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 10, 0);
      chk($sformatf("s%0d ex_ready", k), 64'(ex_ready), 64'd1);
      if (k >= 1 && k <= 9) chk($sformatf("s%0d rs1 bypass", k), rs1_data, 64'(k + 99));
      if (k >= 2) begin
        chk($sformatf("s%0d commit_valid", k), 64'(commit_valid), 64'd1);
        chk($sformatf("s%0d commit_pc", k), commit_pc, 64'h9000_0000 + 64'(4 * (k - 2)));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 10, 0);
    chk("stream end commit_valid", 64'(commit_valid), 64'd0);
    chk("stream end retire_cnt", retire_cnt, 64'd15);
    chk("stream end x10", rs1_data, 64'd108);
    // reset with pending entries under stall
    drive(0, 1, 4, 1, 64'h9, 64'hA000_0000, 0, 4, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 4, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 4, 0);
    chk("x4 written", rs1_data, 64'h9);
    drive(0, 1, 4, 1, 64'h21, 64'hA000_0004, 1, 4, 0);
    drive(0, 1, 6, 1, 64'h22, 64'hA000_0008, 1, 4, 6);
    drive(1, 1, 6, 1, 64'h23, 64'hA000_000C, 1, 4, 6);
    chk("full before reset ex_ready", 64'(ex_ready), 64'd0);
    chk("full before reset rs2 bypass", rs2_data, 64'h22);
    drive(0, 0, 0, 0, 0, 0, 0, 4, 6);
    chk("post reset ex_ready", 64'(ex_ready), 64'd1);
    chk("post reset x4", rs1_data, 64'd0);
    chk("post reset x6", rs2_data, 64'd0);
    chk("post reset retire_cnt", retire_cnt, 64'd0);
    chk("post reset commit_valid", 64'(commit_valid), 64'd0);
    chk("post reset commit_pc", commit_pc, 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 4, 6);
      chk($sformatf("post reset idle%0d commit_valid", k), 64'(commit_valid), 64'd0);
      chk($sformatf("post reset idle%0d retire_cnt", k), retire_cnt, 64'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
